regfile_writeback_queue: RTL and testbench

Write-side companion of the CPU register file: collects completed results from the ALU and the load path, buffers them in a small in-order FIFO and drains one result per cycle onto the register file's single write port. Writes targeting r15 (PC) are not sent to the register file; they are redirected to a PC-load output for the fetch stage. A per-register pending mask lets decode stall on read-after-write hazards while results are still queued.

---
 rtl/regfile_writeback_queue.sv | 124 ++++++++++++
 tb/tb_regfile_writeback_queue.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_writeback_queue.sv
// rtl/regfile_writeback_queue.sv - in-order writeback FIFO feeding the register file write port
// r15 results are diverted to the PC-load output; pending_o exposes queued destinations for hazard stalls.
module regfile_writeback_queue #(
  parameter int DEPTH = 4
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        alu_valid_i,
  input  logic [3:0]  alu_addr_i,
  input  logic [31:0] alu_data_i,
  output logic        alu_ready_o,
  input  logic        ld_valid_i,
  input  logic [3:0]  ld_addr_i,
  input  logic [31:0] ld_data_i,
  output logic        ld_ready_o,
  output logic        wr_en_o,
  output logic [3:0]  wr_addr_o,
  output logic [31:0] wr_data_o,
  output logic        pc_load_o,
  output logic [31:0] pc_data_o,
  output logic [15:0] pending_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] L_FULL   = CW'(DEPTH);
  localparam logic [CW-1:0] L_ALMOST = CW'(DEPTH - 1);

  logic [3:0]    r_q_addr [DEPTH];
  logic [31:0]   r_q_data [DEPTH];
  logic [AW-1:0] r_rd_ptr;
  logic [AW-1:0] r_wr_ptr;
  logic [CW-1:0] r_count;
  logic          r_wr_en;
  logic [3:0]    r_wr_addr;
  logic [31:0]   r_wr_data;
  logic          r_pc_load;
  logic [31:0]   r_pc_data;

  logic          w_ld_ready;
  logic          w_alu_ready;
  logic          w_ld_push;
  logic          w_alu_push;
  logic          w_pop;
  logic          w_head_is_pc;
  logic [AW-1:0] w_alu_slot;
  logic [3:0]    w_head_addr;
  logic [31:0]   w_head_data;
  logic [15:0]   w_pending;

  // The last free slot is reserved for the load so loads are never starved.
  assign w_ld_ready   = r_count < L_FULL;
  assign w_alu_ready  = (r_count < L_ALMOST) || (w_ld_ready && !ld_valid_i);
  assign w_ld_push    = ld_valid_i && w_ld_ready;
  assign w_alu_push   = alu_valid_i && w_alu_ready;
  assign w_pop        = r_count != '0;
  assign w_alu_slot   = r_wr_ptr + AW'(w_ld_push);
  assign w_head_addr  = r_q_addr[r_rd_ptr];
  assign w_head_data  = r_q_data[r_rd_ptr];
  assign w_head_is_pc = w_head_addr == 4'hF;

  always_ff @(posedge clk_i) begin
    if (w_ld_push) begin
      r_q_addr[r_wr_ptr] <= ld_addr_i;
      r_q_data[r_wr_ptr] <= ld_data_i;
    end
    if (w_alu_push) begin
      r_q_addr[w_alu_slot] <= alu_addr_i;
      r_q_data[w_alu_slot] <= alu_data_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_count   <= '0;
      r_rd_ptr  <= '0;
      r_wr_ptr  <= '0;
      r_wr_en   <= 1'b0;
      r_wr_addr <= '0;
      r_wr_data <= '0;
      r_pc_load <= 1'b0;
      r_pc_data <= '0;
    end else begin
      r_count   <= r_count + CW'(w_ld_push) + CW'(w_alu_push) - CW'(w_pop);
      r_wr_ptr  <= w_alu_slot + AW'(w_alu_push);
      r_rd_ptr  <= r_rd_ptr + AW'(w_pop);
      r_wr_en   <= w_pop && !w_head_is_pc;
      r_pc_load <= w_pop && w_head_is_pc;
      if (w_pop && !w_head_is_pc) begin
        r_wr_addr <= w_head_addr;
        r_wr_data <= w_head_data;
      end
      if (w_pop && w_head_is_pc) begin
        r_pc_data <= w_head_data;
      end
    end
  end

  // An entry is live when its distance from the read pointer is below the count.
  always_comb begin
    w_pending = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if ({1'b0, AW'(i) - r_rd_ptr} < r_count) begin
        w_pending = w_pending | (16'd1 << r_q_addr[i]);
      end
    end
    if (r_wr_en) begin
      w_pending = w_pending | (16'd1 << r_wr_addr);
    end
    if (r_pc_load) begin
      w_pending[15] = 1'b1;
    end
  end

  assign alu_ready_o = w_alu_ready;
  assign ld_ready_o  = w_ld_ready;
  assign wr_en_o     = r_wr_en;
  assign wr_addr_o   = r_wr_addr;
  assign wr_data_o   = r_wr_data;
  assign pc_load_o   = r_pc_load;
  assign pc_data_o   = r_pc_data;
  assign pending_o   = w_pending;

endmodule

// File: tb/tb_regfile_writeback_queue.sv
// tb/tb_regfile_writeback_queue.sv - self-checking bench for regfile_writeback_queue
module tb_regfile_writeback_queue;

  localparam int DEPTH = 4;

  logic        clk_i = 1'b0;
  logic        reset_i = 1'b1;
  logic        alu_valid_i = 1'b0;
  logic [3:0]  alu_addr_i = '0;
  logic [31:0] alu_data_i = '0;
  logic        alu_ready_o;
  logic        ld_valid_i = 1'b0;
  logic [3:0]  ld_addr_i = '0;
  logic [31:0] ld_data_i = '0;
  logic        ld_ready_o;
  logic        wr_en_o;
  logic [3:0]  wr_addr_o;
  logic [31:0] wr_data_o;
  logic        pc_load_o;
  logic [31:0] pc_data_o;
  logic [15:0] pending_o;

  regfile_writeback_queue #(.DEPTH(DEPTH)) dut (
    .clk_i       (clk_i),
    .reset_i     (reset_i),
    .alu_valid_i (alu_valid_i),
    .alu_addr_i  (alu_addr_i),
    .alu_data_i  (alu_data_i),
    .alu_ready_o (alu_ready_o),
    .ld_valid_i  (ld_valid_i),
    .ld_addr_i   (ld_addr_i),
    .ld_data_i   (ld_data_i),
    .ld_ready_o  (ld_ready_o),
    .wr_en_o     (wr_en_o),
    .wr_addr_o   (wr_addr_o),
    .wr_data_o   (wr_data_o),
    .pc_load_o   (pc_load_o),
    .pc_data_o   (pc_data_o),
    .pending_o   (pending_o)
  );

  always #5 clk_i = ~clk_i;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_wr_en"},   wr_en_o,     0);
    check({tag, "_wr_addr"}, wr_addr_o,   0);
    check({tag, "_wr_data"}, wr_data_o,   0);
    check({tag, "_pc_load"}, pc_load_o,   0);
    check({tag, "_pc_data"}, pc_data_o,   0);
    check({tag, "_pending"}, pending_o,   0);
    check({tag, "_alu_rdy"}, alu_ready_o, 1);
    check({tag, "_ld_rdy"},  ld_ready_o,  1);
  endtask

  // Fill-test expectations: order in which accepted entries must drain.
  logic [3:0]  exp_fill_a [10] = '{4'd0, 4'd8, 4'd1, 4'd9, 4'd2, 4'd3, 4'd4, 4'd5, 4'd10, 4'd6};
  logic [31:0] exp_fill_d [10] = '{32'h1000, 32'h2000, 32'h1001, 32'h2001, 32'h1002,
                                   32'h1003, 32'h1004, 32'h1005, 32'h2002, 32'h1006};
  logic        exp_alu_rdy [8] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
  logic [3:0]  obs_a [$];
  logic [31:0] obs_d [$];
  int          li;
  int          ai;
  logic        acc_ld;
  logic        acc_alu;

  logic [35:0] mq [$];
  logic [35:0] m_ent;
  logic        m_wr_en;
  logic [3:0]  m_wr_addr;
  logic [31:0] m_wr_data;
  logic        m_pc_load;
  logic [31:0] m_pc_data;
  logic        e_ld;
  logic        e_alu;
  logic [15:0] e_pend;

  task automatic record();
    if (wr_en_o) begin
      obs_a.push_back(wr_addr_o);
      obs_d.push_back(wr_data_o);
    end
  endtask

  initial begin
    tick();
    tick();
    reset_i = 1'b0;
    #1;
    check_reset_outputs("reset");

    // Single ALU push into an empty queue.
    alu_valid_i = 1'b1; alu_addr_i = 4'd3; alu_data_i = 32'hAA;
    tick();
    alu_valid_i = 1'b0;
    check("t1_k_wr_en", wr_en_o, 0);
    check("t1_k_pend", pending_o, 32'h0008);
    tick();
    check("t1_k1_wr_en", wr_en_o, 1);
    check("t1_k1_addr", wr_addr_o, 3);
    check("t1_k1_data", wr_data_o, 32'hAA);
    check("t1_k1_pend", pending_o, 32'h0008);
    tick();
    check("t1_k2_wr_en", wr_en_o, 0);
    check("t1_k2_pend", pending_o, 0);

    // Load and ALU to the same register in one cycle: load drains first.
    ld_valid_i = 1'b1;  ld_addr_i = 4'd4;  ld_data_i = 32'h11;
    alu_valid_i = 1'b1; alu_addr_i = 4'd4; alu_data_i = 32'h22;
    #1;
    check("t2_alu_rdy", alu_ready_o, 1);
    check("t2_ld_rdy", ld_ready_o, 1);
    tick();
    ld_valid_i = 1'b0; alu_valid_i = 1'b0;
    check("t2_c0_wr_en", wr_en_o, 0);
    check("t2_c0_pend", pending_o, 32'h0010);
    tick();
    check("t2_c1_wr_en", wr_en_o, 1);
    check("t2_c1_addr", wr_addr_o, 4);
    check("t2_c1_data", wr_data_o, 32'h11);
    check("t2_c1_pend", pending_o, 32'h0010);
    tick();
    check("t2_c2_wr_en", wr_en_o, 1);
    check("t2_c2_addr", wr_addr_o, 4);
    check("t2_c2_data", wr_data_o, 32'h22);
    check("t2_c2_pend", pending_o, 32'h0010);
    tick();
    check("t2_c3_wr_en", wr_en_o, 0);
    check("t2_c3_pend", pending_o, 0);

    // Write to r15 becomes a PC load; write outputs hold.
    alu_valid_i = 1'b1; alu_addr_i = 4'd15; alu_data_i = 32'h100;
    tick();
    alu_valid_i = 1'b0;
    check("t3_c0_pc_load", pc_load_o, 0);
    check("t3_c0_pend", pending_o, 32'h8000);
    tick();
    check("t3_c1_pc_load", pc_load_o, 1);
    check("t3_c1_pc_data", pc_data_o, 32'h100);
    check("t3_c1_wr_en", wr_en_o, 0);
    check("t3_c1_addr_hold", wr_addr_o, 4);
    check("t3_c1_data_hold", wr_data_o, 32'h22);
    check("t3_c1_pend", pending_o, 32'h8000);
    tick();
    check("t3_c2_pc_load", pc_load_o, 0);
    check("t3_c2_pend", pending_o, 0);

    // Fill: both sources busy, ALU held while not accepted; 10 entries wrap the ring.
    li = 0; ai = 0;
    obs_a.delete(); obs_d.delete();
    for (int c = 0; c < 8; c++) begin
      ld_valid_i  = (c != 6);
      ld_addr_i   = 4'(li);
      ld_data_i   = 32'h1000 + 32'(li);
      alu_valid_i = (c < 7);
      alu_addr_i  = 4'(8 + ai);
      alu_data_i  = 32'h2000 + 32'(ai);
      #1;
      check($sformatf("t4_alu_rdy_%0d", c), alu_ready_o, exp_alu_rdy[c]);
      check($sformatf("t4_ld_rdy_%0d", c), ld_ready_o, 1);
      acc_ld  = ld_valid_i && ld_ready_o;
      acc_alu = alu_valid_i && alu_ready_o;
      tick();
      record();
      if (acc_ld)  li++;
      if (acc_alu) ai++;
    end
    ld_valid_i = 1'b0; alu_valid_i = 1'b0;
    for (int c = 0; c < 5; c++) begin
      tick();
      record();
    end
    check("t4_count", obs_a.size(), 10);
    for (int j = 0; j < 10; j++) begin
      if (j < obs_a.size()) begin
        check($sformatf("t4_addr_%0d", j), obs_a[j], exp_fill_a[j]);
        check($sformatf("t4_data_%0d", j), obs_d[j], exp_fill_d[j]);
      end
    end
    check("t4_pend_end", pending_o, 0);

    // Reset with three entries queued and a write in flight.
    ld_valid_i = 1'b1;  ld_addr_i = 4'd1;   ld_data_i = 32'hA1;
    alu_valid_i = 1'b1; alu_addr_i = 4'd15; alu_data_i = 32'hB1;
    tick();
    ld_addr_i = 4'd2;  ld_data_i = 32'hA2;
    alu_addr_i = 4'd3; alu_data_i = 32'hB2;
    tick();
    ld_valid_i = 1'b0; alu_valid_i = 1'b0;
    check("t5_pre_wr_en", wr_en_o, 1);
    reset_i = 1'b1;
    tick();
    #1;
    check_reset_outputs("t5_rst");
    reset_i = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tick();
      check($sformatf("t5_post_wr_en_%0d", c), wr_en_o, 0);
      check($sformatf("t5_post_pc_%0d", c), pc_load_o, 0);
      check($sformatf("t5_post_pend_%0d", c), pending_o, 0);
    end

    // Random traffic against a reference queue model.
    mq.delete();
    m_wr_en = 0; m_wr_addr = 0; m_wr_data = 0; m_pc_load = 0; m_pc_data = 0;
    for (int c = 0; c < 1000; c++) begin
      ld_valid_i  = ($urandom_range(0, 9) < 6);
      ld_addr_i   = 4'($urandom_range(0, 15));
      ld_data_i   = $urandom();
      alu_valid_i = ($urandom_range(0, 9) < 6);
      alu_addr_i  = 4'($urandom_range(0, 15));
      alu_data_i  = $urandom();
      #1;
      e_ld  = mq.size() < DEPTH;
      e_alu = (mq.size() < DEPTH - 1) || ((mq.size() < DEPTH) && !ld_valid_i);
      e_pend = '0;
      foreach (mq[j]) e_pend = e_pend | (16'd1 << mq[j][35:32]);
      if (m_wr_en)   e_pend = e_pend | (16'd1 << m_wr_addr);
      if (m_pc_load) e_pend[15] = 1'b1;
      check("rnd_ld_rdy", ld_ready_o, e_ld);
      check("rnd_alu_rdy", alu_ready_o, e_alu);
      check("rnd_pend", pending_o, e_pend);
      check("rnd_wr_en", wr_en_o, m_wr_en);
      check("rnd_wr_addr", wr_addr_o, m_wr_addr);
      check("rnd_wr_data", wr_data_o, m_wr_data);
      check("rnd_pc_load", pc_load_o, m_pc_load);
      check("rnd_pc_data", pc_data_o, m_pc_data);
      if (mq.size() > 0) begin
        m_ent = mq.pop_front();
        if (m_ent[35:32] == 4'hF) begin
          m_pc_load = 1; m_pc_data = m_ent[31:0]; m_wr_en = 0;
        end else begin
          m_wr_en = 1; m_wr_addr = m_ent[35:32]; m_wr_data = m_ent[31:0]; m_pc_load = 0;
        end
      end else begin
        m_wr_en = 0; m_pc_load = 0;
      end
      if (ld_valid_i && e_ld)   mq.push_back({ld_addr_i, ld_data_i});
      if (alu_valid_i && e_alu) mq.push_back({alu_addr_i, alu_data_i});
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
